rx_record_arbiter: RTL and testbench

RX_RECORD_ARBITER -- requirements
Module: rx_record_arbiter

---
 rtl/rx_record_arbiter.sv | 109 ++++++++++
 tb/tb_rx_record_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rx_record_arbiter.sv
// rx_record_arbiter: round-robin selection of one GMII RX stream at a time onto a shared recorder,
// with per-frame timestamp, byte-limit truncation, enforced inter-frame gap and saturating statistics.
module rx_record_arbiter #(
  parameter int NUM_PORT = 4,
  parameter int MAX_LEN  = 1522,
  parameter int GAP_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           local_clock,
  input  logic [8*NUM_PORT-1:0] rxd_in,
  input  logic [NUM_PORT-1:0]   rxdv_in,
  output logic [7:0]            out_rxd,
  output logic                  out_rxdv,
  output logic [3:0]            out_host_id,
  output logic [31:0]           out_frame_ts,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           trunc_cnt
);
  localparam int PW = $clog2(NUM_PORT);
  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  typedef enum logic [1:0] {IDLE, FWD, GAP} state_t;
  state_t state, state_nx;
  logic [NUM_PORT-1:0] prev_dv, rise;
  logic [2*NUM_PORT-1:0] rot;
  logic armed, found, grant, fwd, trunc, cur_dv;
  logic [PW-1:0] g, rr_ptr, pick;
  logic [3:0] cnt_rise, ndrop;
  logic [BW-1:0] byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic [16:0] drop_sum;
  // armed masks the first cycle after reset so a port already high is treated as mid-frame
  assign rise = armed ? rxdv_in & ~prev_dv : '0;
  assign rot = {rise, rise} >> rr_ptr;
  assign cur_dv = rxdv_in[g];
  assign out_host_id = 4'(g);
  assign ndrop = cnt_rise - 4'(state == IDLE && found);
  assign drop_sum = {1'b0, drop_cnt} + 17'(ndrop);
  always_comb begin
    found = 1'b0;
    pick = '0;
    cnt_rise = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      cnt_rise = cnt_rise + 4'(rise[i]);
      if (!found && rot[i]) begin
        found = 1'b1;
        pick = PW'((int'(rr_ptr) + i) % NUM_PORT);
      end
    end
  end
  always_comb begin
    state_nx = state;
    grant = 1'b0;
    fwd = 1'b0;
    trunc = 1'b0;
    case (state)
      IDLE: begin
        grant = found;
        state_nx = found ? FWD : IDLE;
      end
      FWD: begin
        trunc = cur_dv && byte_cnt == BW'(MAX_LEN);
        fwd = cur_dv && !trunc;
        state_nx = fwd ? FWD : GAP;
      end
      GAP: state_nx = gap_cnt == GW'(GAP_CYC - 1) ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prev_dv <= '0;
      armed <= 1'b0;
      rr_ptr <= '0;
      g <= '0;
      byte_cnt <= '0;
      gap_cnt <= '0;
      out_rxd <= 8'h00;
      out_rxdv <= 1'b0;
      out_frame_ts <= '0;
      frame_cnt <= '0;
      drop_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      state <= state_nx;
      prev_dv <= rxdv_in;
      armed <= 1'b1;
      out_rxdv <= grant || fwd;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (grant) begin
        g <= pick;
        rr_ptr <= pick == PW'(NUM_PORT - 1) ? '0 : pick + 1'b1;
        out_frame_ts <= local_clock;
        out_rxd <= rxd_in[8*pick +: 8];
        byte_cnt <= BW'(1);
        frame_cnt <= frame_cnt + 16'(frame_cnt != 16'hFFFF);
      end
      if (fwd) begin
        out_rxd <= rxd_in[8*g +: 8];
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (trunc) trunc_cnt <= trunc_cnt + 16'(trunc_cnt != 16'hFFFF);
    end
  end
endmodule

// File: tb/tb_rx_record_arbiter.sv
// tb_rx_record_arbiter: directed scenarios with a cycle-exact scoreboard of expected forwarded bytes;
// a second instance with MAX_LEN=64 covers truncation.
module tb_rx_record_arbiter;
  localparam int NP = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] local_clock = '0;
  logic [8*NP-1:0] rxd_in = '0;
  logic [NP-1:0] rxdv_in = '0;
  logic [7:0] o_rxd, t_rxd;
  logic o_rxdv, t_rxdv;
  logic [3:0] o_host, t_host;
  logic [31:0] o_ts, t_ts;
  logic [15:0] f_cnt, d_cnt, tr_cnt, tf_cnt, td_cnt, ttr_cnt;
  int nvec = 0, nerr = 0, tcnt = 0;
  logic [12:0] sb[$];
  int st[NP], ln[NP];
  bit ex[NP];
  logic [31:0] lc_base = '0;

  rx_record_arbiter #(.NUM_PORT(NP), .MAX_LEN(1522), .GAP_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .local_clock(local_clock), .rxd_in(rxd_in), .rxdv_in(rxdv_in),
    .out_rxd(o_rxd), .out_rxdv(o_rxdv), .out_host_id(o_host), .out_frame_ts(o_ts),
    .frame_cnt(f_cnt), .drop_cnt(d_cnt), .trunc_cnt(tr_cnt));
  rx_record_arbiter #(.NUM_PORT(NP), .MAX_LEN(64), .GAP_CYC(2)) dut_t (
    .clk(clk), .rst_n(rst_n), .local_clock(local_clock), .rxd_in(rxd_in), .rxdv_in(rxdv_in),
    .out_rxd(t_rxd), .out_rxdv(t_rxdv), .out_host_id(t_host), .out_frame_ts(t_ts),
    .frame_cnt(tf_cnt), .drop_cnt(td_cnt), .trunc_cnt(ttr_cnt));

  always #5 clk = ~clk;

  function automatic logic [7:0] dat(int p, int i);
    return i < 7 ? 8'h55 : i == 7 ? 8'hD5 : 8'(p * 40 + i);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(int c);
    logic [12:0] e;
    bit a;
    e = '0;
    local_clock = lc_base + 32'(c);
    for (int p = 0; p < NP; p++) begin
      a = c >= st[p] && c < st[p] + ln[p];
      rxdv_in[p] = a;
      rxd_in[8*p +: 8] = a ? dat(p, c - st[p]) : 8'h00;
      if (a && ex[p]) e = {1'b1, 4'(p), dat(p, c - st[p])};
    end
    sb.push_back(e);
  endtask

  task automatic chk();
    logic [12:0] e;
    @(posedge clk);
    @(negedge clk);
    if (t_rxdv) tcnt++;
    if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
    else begin
      e = sb.pop_front();
      if (e[12]) check("fwd", {19'b0, o_rxdv, o_host, o_rxd}, {19'b0, e});
      else check("idle_rxdv", 32'(o_rxdv), 32'd0);
    end
  endtask

  task automatic run_from(int a, int b);
    for (int c = a; c < b; c++) begin
      drive(c);
      chk();
    end
  endtask

  task automatic clr();
    for (int p = 0; p < NP; p++) begin
      st[p] = 0;
      ln[p] = 0;
      ex[p] = 1'b0;
    end
    tcnt = 0;
  endtask

  task automatic zero_chk(string tag);
    check({tag, "_rxdv"}, 32'(o_rxdv), 32'd0);
    check({tag, "_rxd"}, 32'(o_rxd), 32'd0);
    check({tag, "_host"}, 32'(o_host), 32'd0);
    check({tag, "_ts"}, o_ts, 32'd0);
    check({tag, "_cnts"}, {f_cnt, d_cnt}, 32'd0);
    check({tag, "_trunc"}, 32'(tr_cnt), 32'd0);
    check({tag, "_t_cnts"}, {tf_cnt, ttr_cnt}, 32'd0);
    check({tag, "_t_rxdv"}, 32'(t_rxdv), 32'd0);
  endtask

  initial begin
    clr();
    @(negedge clk);
    @(negedge clk);
    zero_chk("reset");
    // port 1 already high at release must not start a frame
    st[1] = 0; ln[1] = 6;
    drive(0);
    rst_n = 1'b1;
    chk();
    run_from(1, 10);
    check("hi_at_release_frames", 32'(f_cnt), 32'd0);
    check("hi_at_release_drops", 32'(d_cnt), 32'd0);
    // single 72-byte frame on port 2
    clr(); lc_base = 32'h100;
    st[2] = 0; ln[2] = 72; ex[2] = 1'b1;
    run_from(0, 80);
    check("single_frames", 32'(f_cnt), 32'd1);
    check("single_host", 32'(o_host), 32'd2);
    check("single_ts", o_ts, 32'h100);
    check("single_trunc", 32'(tr_cnt), 32'd0);
    check("single_t_bytes", 32'(tcnt), 32'd64);
    check("single_t_trunc", 32'(ttr_cnt), 32'd1);
    // port 3 alone moves rr_ptr back to 0
    clr(); lc_base = 32'h1000;
    st[3] = 0; ln[3] = 10; ex[3] = 1'b1;
    run_from(0, 16);
    check("p3_frames", 32'(f_cnt), 32'd2);
    // simultaneous 0/3: port 0 first, then port 3
    clr();
    ln[0] = 12; ln[3] = 12; ex[0] = 1'b1;
    run_from(0, 18);
    check("simul1_host", 32'(o_host), 32'd0);
    check("simul1_drops", 32'(d_cnt), 32'd1);
    clr();
    ln[0] = 12; ln[3] = 12; ex[3] = 1'b1;
    run_from(0, 18);
    check("simul2_host", 32'(o_host), 32'd3);
    check("simul2_drops", 32'(d_cnt), 32'd2);
    check("simul2_frames", 32'(f_cnt), 32'd4);
    // port 1 starts while port 0 is busy
    clr();
    ln[0] = 20; ex[0] = 1'b1; st[1] = 5; ln[1] = 10;
    run_from(0, 26);
    check("busy_drops", 32'(d_cnt), 32'd3);
    check("busy_frames", 32'(f_cnt), 32'd5);
    check("busy_host", 32'(o_host), 32'd0);
    // port 1 during GAP dropped, port 2 three cycles after end granted
    clr(); lc_base = 32'h2000;
    ln[0] = 10; ex[0] = 1'b1; st[1] = 11; ln[1] = 5; st[2] = 13; ln[2] = 8; ex[2] = 1'b1;
    run_from(0, 28);
    check("gap_drops", 32'(d_cnt), 32'd4);
    check("gap_frames", 32'(f_cnt), 32'd7);
    check("gap_host", 32'(o_host), 32'd2);
    check("gap_ts", o_ts, 32'h200D);
    // 100-byte frame: full instance forwards all, MAX_LEN=64 instance cuts at 64
    clr();
    ln[0] = 100; ex[0] = 1'b1;
    run_from(0, 106);
    check("trunc_t_bytes", 32'(tcnt), 32'd64);
    check("trunc_t_cnt", 32'(ttr_cnt), 32'd2);
    check("trunc_full_cnt", 32'(tr_cnt), 32'd0);
    check("trunc_t_frames", 32'(tf_cnt), 32'd8);
    clr();
    st[0] = 2; ln[0] = 12; ex[0] = 1'b1;
    run_from(0, 18);
    check("regrant_t_frames", 32'(tf_cnt), 32'd9);
    check("regrant_t_bytes", 32'(tcnt), 32'd12);
    check("regrant_frames", 32'(f_cnt), 32'd9);
    // reset asserted during byte 20 of a port 0 frame
    clr(); lc_base = 32'h3000;
    ln[0] = 40; ex[0] = 1'b1;
    run_from(0, 20);
    drive(20);
    void'(sb.pop_back());
    rst_n = 1'b0;
    #1;
    zero_chk("midrst");
    @(posedge clk);
    @(negedge clk);
    drive(21);
    void'(sb.pop_back());
    @(posedge clk);
    @(negedge clk);
    ex[0] = 1'b0;
    drive(22);
    rst_n = 1'b1;
    chk();
    run_from(23, 46);
    check("postrst_frames", 32'(f_cnt), 32'd0);
    clr(); lc_base = 32'h4000;
    st[3] = 2; ln[3] = 10; ex[3] = 1'b1;
    run_from(0, 16);
    check("postrst_frames2", 32'(f_cnt), 32'd1);
    check("postrst_drops", 32'(d_cnt), 32'd0);
    check("postrst_host", 32'(o_host), 32'd3);
    check("postrst_ts", o_ts, 32'h4002);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
